// File: rtl/quad_decoder_array_if.sv
// Bus bundle for the multi-channel quadrature decoder.
// err_cnt_flat only exists when QUAD_ERR_CNT_EN is defined.
interface quad_decoder_array_if #(
  parameter int NUM_CH  = 12,
  parameter int COUNT_W = 32,
  parameter int ERR_W   = 8
);
  logic [NUM_CH-1:0]         quad_a;
  logic [NUM_CH-1:0]         quad_b;
  logic [NUM_CH-1:0]         clr;
  logic                      snap;
  logic [NUM_CH*COUNT_W-1:0] count_flat;
  logic [NUM_CH*COUNT_W-1:0] snap_flat;
  logic                      snap_valid;
  logic [NUM_CH-1:0]         err;
`ifdef QUAD_ERR_CNT_EN
  logic [NUM_CH*ERR_W-1:0]   err_cnt_flat;

  modport master (
    output quad_a, quad_b, clr, snap,
    input  count_flat, snap_flat, snap_valid, err, err_cnt_flat
  );
  modport slave (
    input  quad_a, quad_b, clr, snap,
    output count_flat, snap_flat, snap_valid, err, err_cnt_flat
  );
`else
  modport master (
    output quad_a, quad_b, clr, snap,
    input  count_flat, snap_flat, snap_valid, err
  );
  modport slave (
    input  quad_a, quad_b, clr, snap,
    output count_flat, snap_flat, snap_valid, err
  );
`endif
endinterface

// File: rtl/quad_decoder_array.sv
// Multi-channel 4x quadrature decoder with coherent snapshot.
// Define QUAD_ERR_CNT_EN to add saturating illegal-transition counters.
module quad_decoder_array #(
  parameter int NUM_CH   = 12,
  parameter int COUNT_W  = 32,
  parameter int FILT_LEN = 4,
  parameter int ERR_W    = 8
) (
  input logic clk,
  input logic reset,
  quad_decoder_array_if.slave bus
);
  localparam logic [3:0] STAB_MAX = 4'(FILT_LEN - 1);

  logic [NUM_CH-1:0]         a_s1, a_s2, b_s1, b_s2;
  logic [1:0]                start_q;
  logic                      ld, run;
  logic [1:0]                s2     [NUM_CH];
  logic [1:0]                filt_q [NUM_CH];
  logic [1:0]                prev_q [NUM_CH];
  logic [3:0]                stab_q [NUM_CH][2];
  logic [1:0]                dlt    [NUM_CH];
  logic [COUNT_W-1:0]        cnt_q  [NUM_CH];
  logic [NUM_CH-1:0]         err_q;
  logic [NUM_CH*COUNT_W-1:0] cnt_flat;
  logic [NUM_CH*COUNT_W-1:0] snap_q;
  logic                      snap_v_q;

  assign ld  = start_q == 2'd2;
  assign run = start_q == 2'd3;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_s1    <= '0;
      a_s2    <= '0;
      b_s1    <= '0;
      b_s2    <= '0;
      start_q <= '0;
    end else begin
      a_s1 <= bus.quad_a;
      a_s2 <= a_s1;
      b_s1 <= bus.quad_b;
      b_s2 <= b_s1;
      if (!run) start_q <= start_q + 2'd1;
    end
  end

  // Gray index {B, A^B}: forward order 00,10,11,01 maps to 0,1,2,3
  always_comb begin
    cnt_flat = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      s2[i]  = {a_s2[i], b_s2[i]};
      dlt[i] = {filt_q[i][0], ^filt_q[i]}
             - {prev_q[i][0], ^prev_q[i]};
      cnt_flat[i*COUNT_W +: COUNT_W] = cnt_q[i];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        filt_q[i]    <= '0;
        prev_q[i]    <= '0;
        stab_q[i][0] <= '0;
        stab_q[i][1] <= '0;
      end
    end else if (ld) begin
      for (int i = 0; i < NUM_CH; i++) begin
        filt_q[i]    <= s2[i];
        prev_q[i]    <= s2[i];
        stab_q[i][0] <= '0;
        stab_q[i][1] <= '0;
      end
    end else if (run) begin
      for (int i = 0; i < NUM_CH; i++) begin
        prev_q[i] <= filt_q[i];
        for (int j = 0; j < 2; j++) begin
          if (s2[i][j] == filt_q[i][j]) begin
            stab_q[i][j] <= '0;
          end else if (stab_q[i][j] == STAB_MAX) begin
            filt_q[i][j] <= s2[i][j];
            stab_q[i][j] <= '0;
          end else begin
            stab_q[i][j] <= stab_q[i][j] + 4'd1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_q <= '0;
      for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (bus.clr[i]) begin
          cnt_q[i] <= '0;
          err_q[i] <= 1'b0;
        end else if (run) begin
          unique case (dlt[i])
            2'd1:    cnt_q[i] <= cnt_q[i] + COUNT_W'(1);
            2'd3:    cnt_q[i] <= cnt_q[i] - COUNT_W'(1);
            2'd2:    err_q[i] <= 1'b1;
            default: ;
          endcase
        end
      end
    end
  end

  // Snapshot takes the pre-update counts, so clr on the same edge is not seen
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      snap_q   <= '0;
      snap_v_q <= 1'b0;
    end else begin
      snap_v_q <= bus.snap;
      if (bus.snap) snap_q <= cnt_flat;
    end
  end

  assign bus.count_flat = cnt_flat;
  assign bus.snap_flat  = snap_q;
  assign bus.snap_valid = snap_v_q;
  assign bus.err        = err_q;

`ifdef QUAD_ERR_CNT_EN
  logic [ERR_W-1:0]        ecnt_q [NUM_CH];
  logic [NUM_CH*ERR_W-1:0] ecnt_flat;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) ecnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (bus.clr[i])
          ecnt_q[i] <= '0;
        else if (run && dlt[i] == 2'd2 && ecnt_q[i] != '1)
          ecnt_q[i] <= ecnt_q[i] + ERR_W'(1);
      end
    end
  end

  always_comb begin
    ecnt_flat = '0;
    for (int i = 0; i < NUM_CH; i++)
      ecnt_flat[i*ERR_W +: ERR_W] = ecnt_q[i];
  end

  assign bus.err_cnt_flat = ecnt_flat;
`endif
endmodule

// File: doc/quad_decoder_array.md
# quad_decoder_array

Parametrised multi-channel quadrature encoder decoder for the motor-control fabric; it replaces the fixed per-encoder counters feeding the HPS quadrature PIO inputs. Each channel synchronises and glitch-filters its A/B inputs, decodes 4x quadrature into a signed wrapping position count, and flags illegal transitions. A single snapshot strobe latches every channel's count in the same cycle, so the HPS reads one coherent position set for PID. Per-channel clear inputs are driven from the quad-reset PIO.

## Interface
Parameters:
- NUM_CH, 12: number of encoder channels (1..32)
- COUNT_W, 32: position counter width, two's complement
- FILT_LEN, 4: consecutive stable cycles required before a filtered input changes (1..15)
- ERR_W, 8: illegal-transition counter width (used only with QUAD_ERR_CNT_EN)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- quad_a  in  NUM_CH  encoder A inputs, asynchronous to clk
- quad_b  in  NUM_CH  encoder B inputs, asynchronous to clk
- clr  in  NUM_CH  per-channel synchronous clear, level
- snap  in  1  snapshot request, single-cycle pulse
- count_flat  out  NUM_CH*COUNT_W  live counts, channel i at [i*COUNT_W +: COUNT_W]
- snap_flat  out  NUM_CH*COUNT_W  snapshot counts, same packing
- snap_valid  out  1  one-cycle pulse when snap_flat updates
- err  out  NUM_CH  sticky illegal-transition flag per channel
- err_cnt_flat  out  NUM_CH*ERR_W  saturating illegal-transition counts (present only with QUAD_ERR_CNT_EN)

## Operation
- Reset: all outputs 0; sync, filter, prev registers 0; startup counter 0.
- Sync: two-flop synchroniser per A and per B input → sync2.
- Startup: on the 3rd clk edge after reset deasserts, filt and prev load sync2 directly; no count, no error. Decoding is enabled from the next edge.
- Filter (per input): stab counter clears whenever sync2 == filt; when sync2 ≠ filt it increments; on the FILT_LEN-th consecutive differing cycle filt <= sync2 and stab clears.
- Decode: prev <= filt every cycle; state pair {A,B}. Forward sequence 00→10→11→01→00 gives +1; reverse gives −1; equal gives no change; both bits changing is illegal: no count change, err[i] set, err_cnt saturating +1.
- Count arithmetic: modulo 2^COUNT_W; 0 − 1 = all ones, max + 1 = 0.
- clr[i] high: count, err[i], err_cnt[i] go to 0 on that edge and hold while clr is high; clr overrides a same-cycle step or error.
- snap: at the edge where snap is high, snap_flat loads every channel's count register value *before* that edge's update; snap_valid is high for the following cycle. snap overlapping clr captures the pre-clear value.
- Channels are independent; simultaneous events on different channels never interact.

## Timing
- Input edge to count change: 3 + FILT_LEN clk edges (7 at default), for a clean input held ≥ FILT_LEN + 2 cycles.
- Pulses shorter than FILT_LEN cycles at sync2 are rejected.
- Maximum decodable step rate: one state change per FILT_LEN + 1 cycles per channel.
- snap → snap_flat/snap_valid: 1 cycle. snap every cycle is legal; snap_valid then stays high.
- clr → count = 0: 1 cycle.
- Asynchronous reset mid-operation: all state clears immediately; the startup sequence reruns after release.

## Configuration
- QUAD_ERR_CNT_EN defined: per-channel ERR_W-bit saturating error counters and the err_cnt_flat port exist.
- Not defined: counters and port are removed; the sticky err flags remain unchanged.

## Test plan
- Reset, FILT_LEN=4, ch0 steps AB 00→10→11→01→00, each held 10 cycles → count0 = 4; first change appears 7 edges after the first input edge.
- Reset, ch1 steps 00→01 once → count1 = 2^32−1 (0xFFFFFFFF); other channels stay 0.
- ch2 jumps 00→11 → count2 unchanged, err[2] = 1, err_cnt2 = 1; 300 further illegal jumps → err_cnt2 saturates at 255.
- ch3 A glitches high for 3 cycles (FILT_LEN=4) → count3 unchanged, err[3] = 0; a 4-cycle pulse → count3 goes +1 then −1.
- count4 = 5; assert snap, clr[4], and a forward step on the same edge → snap_flat ch4 = 5, snap_valid pulses once, count4 = 0.
- Reset asserted mid-stream with inputs at 11 → all outputs 0; after release, no count change and no err from the startup load.
